cdb_arbiter: RTL and testbench

//  Shares the two common data bus lanes (CDB0, CDB1) among the functional-unit

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 47 ++++
 rtl/cdb_arbiter.sv | 106 ++++++++++
 tb/tb_cdb_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-core constants: ROB tag/result widths, functional-unit indices
// and the common data bus packet layout.
package cpu_pkg;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int NUM_FU = 4;

  localparam logic [TAG_W-1:0] INVALID_TAG = 6'd16;

  localparam int FU_ALU = 0;
  localparam int FU_LS  = 1;
  localparam int FU_BR  = 2;
  localparam int FU_MUL = 3;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_pkt_t;
endpackage

// File: rtl/rr_pick2.sv
// Combinational rotating-priority picker: finds the first two set bits of req
// scanning from ptr upward (mod NUM_REQ) and reports the later of the two.
module rr_pick2 #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt0_oh,
  output logic [NUM_REQ-1:0] gnt1_oh,
  output logic               any0,
  output logic               any1,
  output logic [PTR_W-1:0]   last_idx
);

  logic [PTR_W-1:0] rot_idx [NUM_REQ];

  // Scan order; the wrap is an explicit subtract so non-power-of-2 counts work.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [PTR_W:0] sum;
    assign sum = {1'b0, ptr} + (PTR_W+1)'(gi);
    assign rot_idx[gi] = (sum >= (PTR_W+1)'(NUM_REQ)) ?
                         PTR_W'(sum - (PTR_W+1)'(NUM_REQ)) : PTR_W'(sum);
  end

  always_comb begin
    gnt0_oh  = '0;
    gnt1_oh  = '0;
    any0     = 1'b0;
    any1     = 1'b0;
    last_idx = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req[rot_idx[k]]) begin
        if (!any0) begin
          gnt0_oh[rot_idx[k]] = 1'b1;
          any0                = 1'b1;
          last_idx            = rot_idx[k];
        end else if (!any1) begin
          gnt1_oh[rot_idx[k]] = 1'b1;
          any1                = 1'b1;
          last_idx            = rot_idx[k];
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-lane common data bus arbiter: grants up to two ready FU results per cycle
// by rotating priority and broadcasts them on registered single-cycle lanes.
module cdb_arbiter #(
  parameter int               NUM_REQ     = cpu_pkg::NUM_FU,
  parameter int               TAG_W       = cpu_pkg::TAG_W,
  parameter int               DATA_W      = cpu_pkg::DATA_W,
  parameter logic [TAG_W-1:0] INVALID_TAG = TAG_W'(cpu_pkg::INVALID_TAG),
  localparam int              PTR_W       = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb0_valid,
  output logic [TAG_W-1:0]          cdb0_tag,
  output logic [DATA_W-1:0]         cdb0_data,
  output logic                      cdb1_valid,
  output logic [TAG_W-1:0]          cdb1_tag,
  output logic [DATA_W-1:0]         cdb1_data,
  output logic [PTR_W-1:0]          rr_ptr_o
);

  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] gnt0_oh, gnt1_oh;
  logic               any0, any1;
  logic [PTR_W-1:0]   last_idx;
  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [TAG_W-1:0]   tag0_next, tag1_next;
  logic [DATA_W-1:0]  data0_next, data1_next;
  logic               lane0_valid_reg, lane1_valid_reg;
  logic [TAG_W-1:0]   lane0_tag_reg, lane1_tag_reg;
  logic [DATA_W-1:0]  lane0_data_reg, lane1_data_reg;

  // Masking here keeps grants off while reset is asserted, even mid-cycle.
  assign req_eff = (reset || flush) ? '0 : req_valid;

  rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
    .req      (req_eff),
    .ptr      (rr_ptr_reg),
    .gnt0_oh  (gnt0_oh),
    .gnt1_oh  (gnt1_oh),
    .any0     (any0),
    .any1     (any1),
    .last_idx (last_idx)
  );

  assign req_ready = gnt0_oh | gnt1_oh;

  always_comb begin
    tag0_next  = INVALID_TAG;
    data0_next = '0;
    tag1_next  = INVALID_TAG;
    data1_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt0_oh[i]) begin
        tag0_next  = req_tag[i*TAG_W +: TAG_W];
        data0_next = req_data[i*DATA_W +: DATA_W];
      end
      if (gnt1_oh[i]) begin
        tag1_next  = req_tag[i*TAG_W +: TAG_W];
        data1_next = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (flush) begin
      rr_ptr_next = '0;
    end else if (any0) begin
      rr_ptr_next = (last_idx == PTR_W'(NUM_REQ-1)) ? '0 : last_idx + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane0_valid_reg <= 1'b0;
      lane0_tag_reg   <= INVALID_TAG;
      lane0_data_reg  <= '0;
      lane1_valid_reg <= 1'b0;
      lane1_tag_reg   <= INVALID_TAG;
      lane1_data_reg  <= '0;
      rr_ptr_reg      <= '0;
    end else begin
      lane0_valid_reg <= any0;
      lane0_tag_reg   <= tag0_next;
      lane0_data_reg  <= data0_next;
      lane1_valid_reg <= any1;
      lane1_tag_reg   <= tag1_next;
      lane1_data_reg  <= data1_next;
      rr_ptr_reg      <= rr_ptr_next;
    end
  end

  assign cdb0_valid = lane0_valid_reg;
  assign cdb0_tag   = lane0_tag_reg;
  assign cdb0_data  = lane0_data_reg;
  assign cdb1_valid = lane1_valid_reg;
  assign cdb1_tag   = lane1_tag_reg;
  assign cdb1_data  = lane1_data_reg;
  assign rr_ptr_o   = rr_ptr_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a reference picker predicts grants and lane
// contents each cycle; lane packets are queued and compared one edge later.
module tb_cdb_arbiter;
  import cpu_pkg::*;

  localparam int N = 4;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  flush = 1'b0;
  logic [N-1:0]          req_valid = '0;
  logic [N*TAG_W-1:0]    req_tag = '0;
  logic [N*DATA_W-1:0]   req_data = '0;
  logic [N-1:0]          req_ready;
  logic                  cdb0_valid, cdb1_valid;
  logic [TAG_W-1:0]      cdb0_tag, cdb1_tag;
  logic [DATA_W-1:0]     cdb0_data, cdb1_data;
  logic [1:0]            rr_ptr_o;

  always #5 clock = ~clock;

  cdb_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_tag    (req_tag),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .cdb0_valid (cdb0_valid),
    .cdb0_tag   (cdb0_tag),
    .cdb0_data  (cdb0_data),
    .cdb1_valid (cdb1_valid),
    .cdb1_tag   (cdb1_tag),
    .cdb1_data  (cdb1_data),
    .rr_ptr_o   (rr_ptr_o)
  );

  logic              fu_v    [N];
  logic [TAG_W-1:0]  fu_tag  [N];
  logic [DATA_W-1:0] fu_data [N];
  int                wait_cnt [N];
  int                n_cmp = 0;
  int                n_err = 0;
  int                ptr_m = 0;
  int                max_wait = 0;
  bit                soak = 1'b0;
  cdb_pkt_t          exp_q [$];
  logic [N-1:0]      g;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]                = fu_v[i];
      req_tag[i*TAG_W +: TAG_W]   = fu_tag[i];
      req_data[i*DATA_W +: DATA_W] = fu_data[i];
    end
  endtask

  // Called at posedge+1 with fu_* set up; returns the predicted grant mask.
  task automatic cycle(output logic [N-1:0] gnt);
    int w0, w1;
    cdb_pkt_t p0, p1, e0, e1;
    drive();
    w0 = -1;
    w1 = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr_m + k) % N;
      if (fu_v[idx] && !flush) begin
        if (w0 < 0) w0 = idx;
        else if (w1 < 0) w1 = idx;
      end
    end
    gnt = '0;
    if (w0 >= 0) gnt[w0] = 1'b1;
    if (w1 >= 0) gnt[w1] = 1'b1;
    #1;
    check("req_ready", 64'(req_ready), 64'(gnt));

    p0.valid = 1'b0; p0.tag = INVALID_TAG; p0.data = '0;
    p1 = p0;
    if (w0 >= 0) begin p0.valid = 1'b1; p0.tag = fu_tag[w0]; p0.data = fu_data[w0]; end
    if (w1 >= 0) begin p1.valid = 1'b1; p1.tag = fu_tag[w1]; p1.data = fu_data[w1]; end
    exp_q.push_back(p0);
    exp_q.push_back(p1);

    if (flush) ptr_m = 0;
    else if (w1 >= 0) ptr_m = (w1 + 1) % N;
    else if (w0 >= 0) ptr_m = (w0 + 1) % N;

    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        if (soak && wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        wait_cnt[i] = 0;
      end else if (fu_v[i]) begin
        wait_cnt[i]++;
      end
    end

    @(posedge clock);
    #1;
    e0 = exp_q.pop_front();
    e1 = exp_q.pop_front();
    check("cdb0_valid", 64'(cdb0_valid), 64'(e0.valid));
    check("cdb0_tag",   64'(cdb0_tag),   64'(e0.tag));
    check("cdb0_data",  64'(cdb0_data),  64'(e0.data));
    check("cdb1_valid", 64'(cdb1_valid), 64'(e1.valid));
    check("cdb1_tag",   64'(cdb1_tag),   64'(e1.tag));
    check("cdb1_data",  64'(cdb1_data),  64'(e1.data));
    check("rr_ptr",     64'(rr_ptr_o),   64'(ptr_m));
    $display("txn t=%0t flush=%0b gnt=%b lane0=%0b/%0d/%h lane1=%0b/%0d/%h ptr=%0d",
             $time, flush, gnt, cdb0_valid, cdb0_tag, cdb0_data,
             cdb1_valid, cdb1_tag, cdb1_data, rr_ptr_o);
    for (int i = 0; i < N; i++) if (gnt[i]) fu_v[i] = 1'b0;
  endtask

  task automatic set_fu(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    fu_v[i]    = 1'b1;
    fu_tag[i]  = t;
    fu_data[i] = d;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      fu_v[i] = 1'b0; fu_tag[i] = '0; fu_data[i] = '0; wait_cnt[i] = 0;
    end

    // Reset state, with a requester present to show grants are masked.
    #1 reset = 1'b1;
    set_fu(FU_ALU, 6'd1, 32'h1111_0000);
    drive();
    #2;
    check("rst_ready",  64'(req_ready),  64'd0);
    check("rst_v0",     64'(cdb0_valid), 64'd0);
    check("rst_tag0",   64'(cdb0_tag),   64'(INVALID_TAG));
    check("rst_v1",     64'(cdb1_valid), 64'd0);
    check("rst_tag1",   64'(cdb1_tag),   64'(INVALID_TAG));
    check("rst_ptr",    64'(rr_ptr_o),   64'd0);
    fu_v[FU_ALU] = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;

    // Single request from the branch unit.
    set_fu(FU_BR, 6'd5, 32'hDEAD_BEEF);
    cycle(g);

    // Reset mid-broadcast: lanes currently carry FU2's result.
    set_fu(FU_LS, 6'd9, 32'h0000_0099);
    drive();
    check("pre_rst_v0", 64'(cdb0_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_v0",    64'(cdb0_valid), 64'd0);
    check("mid_rst_tag0",  64'(cdb0_tag),   64'(INVALID_TAG));
    check("mid_rst_v1",    64'(cdb1_valid), 64'd0);
    check("mid_rst_tag1",  64'(cdb1_tag),   64'(INVALID_TAG));
    check("mid_rst_ptr",   64'(rr_ptr_o),   64'd0);
    check("mid_rst_ready", 64'(req_ready),  64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    ptr_m = 0;

    // All four valid from ptr=0 (FU1 still pending from before the reset).
    set_fu(FU_ALU, 6'd10, 32'hA0A0_0000);
    set_fu(FU_BR,  6'd12, 32'hC0C0_0002);
    set_fu(FU_MUL, 6'd13, 32'hD0D0_0003);
    cycle(g);
    check("all4_c1", 64'(g), 64'b0011);
    cycle(g);
    check("all4_c2", 64'(g), 64'b1100);

    // Back-pressure: move ptr to 2, then FU1/FU2/FU3 compete.
    set_fu(FU_ALU, 6'd20, 32'h2000_0000);
    set_fu(FU_LS,  6'd21, 32'h2100_0001);
    cycle(g);
    set_fu(FU_LS,  6'd22, 32'h2200_0001);
    set_fu(FU_BR,  6'd23, 32'h2300_0002);
    set_fu(FU_MUL, 6'd16, 32'h2400_0003);
    cycle(g);
    check("bp_first", 64'(g), 64'b1100);
    cycle(g);
    check("bp_stall", 64'(g), 64'b0010);

    // Flush with everyone valid.
    for (int i = 0; i < N; i++) set_fu(i, 6'(30 + i), 32'h3000_0000 + 32'(i));
    flush = 1'b1;
    cycle(g);
    flush = 1'b0;
    cycle(g);
    check("post_flush", 64'(g), 64'b0011);
    cycle(g);

    // Random soak.
    soak = 1'b1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!fu_v[i] && $urandom_range(1, 0) == 1)
          set_fu(i, 6'($urandom_range(63, 0)), $urandom);
      end
      cycle(g);
    end
    for (int i = 0; i < N; i++) fu_v[i] = 1'b0;
    cycle(g);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("max_wait_le2", 64'(max_wait <= 2), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
